// File: rtl/gpio_edge_irq_if.sv
`default_nettype none
// ============================================================================
// Module   : gpio_edge_irq_if
// Brief    : Avalon-MM slave bus bundle for the edge-capturing GPIO port.
// Revision : 1.0
// ============================================================================
interface gpio_edge_irq_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface
`default_nettype wire

// File: rtl/gpio_edge_irq.sv
`default_nettype none
// ============================================================================
// Module   : gpio_edge_irq
// Brief    : Bidirectional GPIO with input synchroniser, per-bit edge capture,
//            masked level interrupt and atomic output set/clear.
// Revision : 1.0
// ============================================================================
module gpio_edge_irq #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    SYNC_STAGES = 2,
    parameter int                    EDGE_TYPE   = 0,
    parameter logic [DATA_WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_DIR   = '0
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    gpio_edge_irq_if.slave             bus,
    output logic                       irq,
    inout  wire logic [DATA_WIDTH-1:0] bidir_port
);

    localparam logic [2:0] c_ADDR_DATA = 3'd0;
    localparam logic [2:0] c_ADDR_DIR  = 3'd1;
    localparam logic [2:0] c_ADDR_MASK = 3'd2;
    localparam logic [2:0] c_ADDR_EDGE = 3'd3;
    localparam logic [2:0] c_ADDR_SET  = 3'd4;
    localparam logic [2:0] c_ADDR_CLR  = 3'd5;

    logic [DATA_WIDTH-1:0] r_data_out;
    logic [DATA_WIDTH-1:0] r_data_dir;
    logic [DATA_WIDTH-1:0] r_irq_mask;
    logic [DATA_WIDTH-1:0] r_edge_cap;
    logic [DATA_WIDTH-1:0] r_prev_in;
    logic [DATA_WIDTH-1:0] r_sync [SYNC_STAGES];

    logic                  w_wr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_sync_in;
    logic [DATA_WIDTH-1:0] w_edge;
    logic [DATA_WIDTH-1:0] w_cap_clr;
    logic [31:0]           w_rd_data;

    assign w_wr      = bus.chipselect & ~bus.write_n;
    assign w_wdata   = bus.writedata[DATA_WIDTH-1:0];
    assign w_sync_in = r_sync[SYNC_STAGES-1];
    assign w_cap_clr = (w_wr && bus.address == c_ADDR_EDGE) ? w_wdata : '0;

    generate
        for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_pin
            assign bidir_port[i] = r_data_dir[i] ? r_data_out[i] : 1'bz;
        end

        if (EDGE_TYPE == 0) begin : g_rise
            assign w_edge = w_sync_in & ~r_prev_in;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign w_edge = ~w_sync_in & r_prev_in;
        end else begin : g_any
            assign w_edge = w_sync_in ^ r_prev_in;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_out <= RESET_OUT;
            r_data_dir <= RESET_DIR;
            r_irq_mask <= '0;
        end else if (w_wr) begin
            case (bus.address)
                c_ADDR_DATA: r_data_out <= w_wdata;
                c_ADDR_DIR:  r_data_dir <= w_wdata;
                c_ADDR_MASK: r_irq_mask <= w_wdata;
                c_ADDR_SET:  r_data_out <= r_data_out | w_wdata;
                c_ADDR_CLR:  r_data_out <= r_data_out & ~w_wdata;
                default: ;
            endcase
        end
    end

    // Pins are sampled including outputs, so driven bits read back through the same chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev_in <= '0;
        end else begin
            r_sync[0] <= bidir_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev_in <= w_sync_in;
        end
    end

    // A fresh edge overrides a simultaneous write-1-to-clear on the same bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edge_cap <= '0;
        end else begin
            r_edge_cap <= (r_edge_cap & ~w_cap_clr) | w_edge;
        end
    end

    always_comb begin
        w_rd_data = '0;
        case (bus.address)
            c_ADDR_DATA: w_rd_data[DATA_WIDTH-1:0] = w_sync_in;
            c_ADDR_DIR:  w_rd_data[DATA_WIDTH-1:0] = r_data_dir;
            c_ADDR_MASK: w_rd_data[DATA_WIDTH-1:0] = r_irq_mask;
            c_ADDR_EDGE: w_rd_data[DATA_WIDTH-1:0] = r_edge_cap;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= w_rd_data;
        end
    end

    assign irq = |(r_edge_cap & r_irq_mask);

endmodule
`default_nettype wire

// File: tb/tb_gpio_edge_irq.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_edge_irq
// Brief    : Directed self-checking bench for gpio_edge_irq (32-bit and 8-bit).
// Revision : 1.0
// ============================================================================
module tb_gpio_edge_irq;

    logic        clk;
    logic        rst;
    logic        irq_a;
    logic        irq_b;
    wire  [31:0] pa;
    wire  [7:0]  pb;
    logic        ext_a_en;
    logic [15:0] ext_hi;
    logic        ext_b_en;
    logic [7:0]  ext_b;
    logic [31:0] rdv;
    int          n_checks;
    int          n_fail;

    gpio_edge_irq_if ifa ();
    gpio_edge_irq_if ifb ();

    assign pa[31:16] = ext_a_en ? ext_hi : 16'bz;
    assign pb        = ext_b_en ? ext_b  : 8'bz;

    gpio_edge_irq #(
        .DATA_WIDTH (32),
        .SYNC_STAGES(2),
        .EDGE_TYPE  (0),
        .RESET_OUT  (32'h0000_00A5),
        .RESET_DIR  (32'h0000_FFFF)
    ) u_dut_a (
        .clk       (clk),
        .reset     (rst),
        .bus       (ifa.slave),
        .irq       (irq_a),
        .bidir_port(pa)
    );

    gpio_edge_irq #(
        .DATA_WIDTH (8),
        .SYNC_STAGES(3),
        .EDGE_TYPE  (2),
        .RESET_OUT  (8'h00),
        .RESET_DIR  (8'h00)
    ) u_dut_b (
        .clk       (clk),
        .reset     (rst),
        .bus       (ifb.slave),
        .irq       (irq_b),
        .bidir_port(pb)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        ifa.chipselect = 1'b0; ifa.write_n = 1'b1; ifa.address = 3'd0; ifa.writedata = '0;
        ifb.chipselect = 1'b0; ifb.write_n = 1'b1; ifb.address = 3'd0; ifb.writedata = '0;
    endtask

    // Called at a negedge; the write is presented on the following posedge.
    task automatic wr(input bit sel, input logic [2:0] a, input logic [31:0] d);
        if (!sel) begin
            ifa.address = a; ifa.chipselect = 1'b1; ifa.write_n = 1'b0; ifa.writedata = d;
        end else begin
            ifb.address = a; ifb.chipselect = 1'b1; ifb.write_n = 1'b0; ifb.writedata = d;
        end
        @(negedge clk);
        bus_idle();
    endtask

    task automatic rd(input bit sel, input logic [2:0] a, output logic [31:0] d);
        if (!sel) begin
            ifa.address = a; ifa.chipselect = 1'b1;
        end else begin
            ifb.address = a; ifb.chipselect = 1'b1;
        end
        @(negedge clk);
        d = sel ? ifb.readdata : ifa.readdata;
        bus_idle();
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1;
        n_checks = 0; n_fail = 0;
        ext_a_en = 1'b1; ext_hi = 16'h0000;
        ext_b_en = 1'b1; ext_b  = 8'h00;
        bus_idle();
        wait_cyc(2);

        check_val("rst_irq_a",  {31'd0, irq_a}, 32'd0);
        check_val("rst_pins_a", {16'd0, pa[15:0]}, 32'h0000_00A5);
        check_val("rst_rd_a",   ifa.readdata, 32'd0);
        check_val("rst_irq_b",  {31'd0, irq_b}, 32'd0);
        check_val("rst_rd_b",   ifb.readdata, 32'd0);
        rst = 1'b0;

        // Pins high at reset release show up as rising captures.
        wait_cyc(6);
        rd(0, 3'd3, rdv); check_val("powerup_cap", rdv, 32'h0000_00A5);
        wr(0, 3'd3, 32'hFFFF_FFFF);
        rd(0, 3'd3, rdv); check_val("cap_cleared", rdv, 32'd0);

        wr(0, 3'd0, 32'h0000_0F0F);
        check_val("pins_load", {16'd0, pa[15:0]}, 32'h0000_0F0F);
        wr(0, 3'd4, 32'h0000_F000);
        wr(0, 3'd5, 32'h0000_000F);
        check_val("pins_setclr", {16'd0, pa[15:0]}, 32'h0000_FF00);
        wait_cyc(4);
        rd(0, 3'd0, rdv); check_val("rd_sync_in", rdv, 32'h0000_FF00);
        rd(0, 3'd3, rdv); check_val("cap_rises", rdv, 32'h0000_FF0A);
        wr(0, 3'd3, 32'hFFFF_FFFF);

        // Rising edge on bit0 with mask bit0: irq exactly SYNC_STAGES+1 after the pin.
        wr(0, 3'd2, 32'h0000_0001);
        wr(0, 3'd4, 32'h0000_0001);
        wait_cyc(1); check_val("irq_lat_c1", {31'd0, irq_a}, 32'd0);
        wait_cyc(1); check_val("irq_lat_c2", {31'd0, irq_a}, 32'd0);
        wait_cyc(1); check_val("irq_lat_c3", {31'd0, irq_a}, 32'd1);
        rd(0, 3'd3, rdv); check_val("cap_bit0", rdv, 32'h0000_0001);
        wr(0, 3'd3, 32'h0000_0001);
        check_val("irq_cleared", {31'd0, irq_a}, 32'd0);
        wr(0, 3'd5, 32'h0000_0001);
        wait_cyc(5);
        rd(0, 3'd3, rdv); check_val("fall_no_cap", rdv, 32'd0);
        check_val("fall_no_irq", {31'd0, irq_a}, 32'd0);

        // One-cycle low pulse: the re-rise is detected exactly when the clear lands.
        wr(0, 3'd4, 32'h0000_0001);
        wait_cyc(5);
        check_val("irq_pre_race", {31'd0, irq_a}, 32'd1);
        wr(0, 3'd5, 32'h0000_0001);
        wr(0, 3'd4, 32'h0000_0001);
        wait_cyc(2);
        wr(0, 3'd3, 32'h0000_0001);
        check_val("race_irq", {31'd0, irq_a}, 32'd1);
        rd(0, 3'd3, rdv); check_val("race_cap", rdv, 32'h0000_0001);
        wr(0, 3'd3, 32'h0000_0001);
        check_val("late_clr_irq", {31'd0, irq_a}, 32'd0);
        rd(0, 3'd3, rdv); check_val("late_clr_cap", rdv, 32'd0);

        // External input on a pin left as input; mask excludes it.
        ext_hi = 16'h0001;
        wait_cyc(5);
        rd(0, 3'd3, rdv); check_val("ext_cap", rdv, 32'h0001_0000);
        check_val("ext_masked", {31'd0, irq_a}, 32'd0);
        rd(0, 3'd0, rdv); check_val("ext_rd_pins", rdv, 32'h0001_FF01);

        // 8-bit instance, any-edge capture.
        ext_b = 8'h20;
        wait_cyc(6);
        ext_b = 8'h00;
        wait_cyc(6);
        rd(1, 3'd3, rdv); check_val("b_cap_any", rdv, 32'h0000_0020);
        check_val("b_irq_masked", {31'd0, irq_b}, 32'd0);
        wr(1, 3'd2, 32'h0000_0020);
        check_val("b_irq_unmask", {31'd0, irq_b}, 32'd1);
        ext_b_en = 1'b0;
        wr(1, 3'd1, 32'hFFFF_FFFF);
        rd(1, 3'd1, rdv); check_val("b_dir_width", rdv, 32'h0000_00FF);
        rd(1, 3'd6, rdv); check_val("b_rsvd_rd", rdv, 32'd0);
        rd(1, 3'd4, rdv); check_val("b_set_rd", rdv, 32'd0);

        // Asynchronous reset mid-operation.
        wr(0, 3'd2, 32'h0001_0000);
        check_val("pre_rst_irq", {31'd0, irq_a}, 32'd1);
        ifa.address = 3'd3;
        wait_cyc(1);
        #1 rst = 1'b1;
        #1;
        check_val("mid_rst_irq",  {31'd0, irq_a}, 32'd0);
        check_val("mid_rst_pins", {16'd0, pa[15:0]}, 32'h0000_00A5);
        check_val("mid_rst_rd",   ifa.readdata, 32'd0);
        wait_cyc(2);
        rst = 1'b0;
        bus_idle();
        wait_cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
